// File: rtl/sum_pkg.sv
// sum_pkg: shared widths, packing rule and state type for the adder-tree datapath
package sum_pkg;
  localparam int NUM_INPUTS_DEF = 16;
  localparam int LANE_W = $clog2(NUM_INPUTS_DEF);
  localparam int COUNT_W = LANE_W + 1;
  typedef enum logic {EMPTY, FILL} pack_state_t;
  function automatic int lane_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int lane_lo(input int k, input int dwidth);
    return k * dwidth;
  endfunction
endpackage

// File: rtl/sum_idle_timer.sv
// sum_idle_timer: counts idle cycles while enabled and pulses expire on the TIMEOUT-th one
module sum_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  if (TIMEOUT > 0) begin : g_on
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] t;
    // idle counter, held at zero when cleared or disabled, saturating at TIMEOUT
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) t <= '0;
      else if (clear || !enable) t <= '0;
      else if (t != TW'(TIMEOUT)) t <= t + 1'b1;
    assign expire = enable && !clear && (t == TW'(TIMEOUT - 1));
  end else begin : g_off
    assign expire = 1'b0;
  end
endmodule

// File: rtl/sum_vec_packer.sv
// sum_vec_packer: packs a serial sample stream into NUM_INPUTS-lane vectors for the adder tree
module sum_vec_packer
  import sum_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH = 8,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic i_dat_valid,
  input  logic i_last,
  output logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector,
  output logic o_dat_valid,
  output logic [lane_w(NUM_INPUTS):0] o_lane_count
);
  localparam int LW = lane_w(NUM_INPUTS);
  localparam int CW = LW + 1;
  pack_state_t state_q, state_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [NUM_INPUTS*DWIDTH-1:0] buf_q, buf_d, wr_buf;
  logic [CW-1:0] cnt_out;
  logic close, flush, emit;
  sum_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(i_dat_valid),
    .enable(state_q == FILL),
    .expire(flush)
  );
  // next state: accept sample into its lane, close on last lane / i_last / timeout
  always_comb begin
    wr_buf = buf_q;
    if (i_dat_valid) wr_buf[lane_lo(int'(fill_q), DWIDTH) +: DWIDTH] = i_dat;
    close = i_dat_valid && (i_last || fill_q == LW'(NUM_INPUTS - 1));
    emit = close || flush;
    cnt_out = close ? CW'(fill_q) + CW'(1) : CW'(fill_q);
    state_d = emit ? EMPTY : (i_dat_valid ? FILL : state_q);
    fill_d = emit ? '0 : (i_dat_valid ? fill_q + 1'b1 : fill_q);
    buf_d = emit ? '0 : wr_buf;
  end
  // collect state and registered output vector, one-cycle valid pulse on emit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      fill_q <= '0;
      buf_q <= '0;
      o_dat_vector <= '0;
      o_dat_valid <= 1'b0;
      o_lane_count <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      buf_q <= buf_d;
      o_dat_valid <= emit;
      if (emit) begin
        o_dat_vector <= wr_buf;
        o_lane_count <= cnt_out;
      end
    end
endmodule

// File: tb/tb_sum_vec_packer.sv
// tb_sum_vec_packer: directed table and sequence checks of the sample packer
module tb_sum_vec_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] i_dat = '0;
  logic i_dat_valid = 1'b0;
  logic i_last = 1'b0;
  logic [127:0] o_dat_vector;
  logic o_dat_valid;
  logic [4:0] o_lane_count;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int n;
    logic [7:0] base;
    logic [7:0] step;
    bit last;
    int exp_cnt;
    logic [127:0] exp_vec;
    int exp_sum;
  } vec_t;
  vec_t tbl[4];
  sum_vec_packer #(.NUM_INPUTS(16), .DWIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_dat(i_dat),
    .i_dat_valid(i_dat_valid),
    .i_last(i_last),
    .o_dat_vector(o_dat_vector),
    .o_dat_valid(o_dat_valid),
    .o_lane_count(o_lane_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic l);
    i_dat_valid = v;
    i_dat = d;
    i_last = l;
    @(negedge clk);
  endtask
  function automatic int sum_lanes(input logic [127:0] v);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(v[k*8 +: 8]);
    return s;
  endfunction
  task automatic wait_pulse(input string nm, input int exp_idle);
    int k = 0;
    for (int j = 1; j <= 100; j++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (o_dat_valid) begin
        k = j;
        break;
      end
    end
    chk(nm, 128'(k), 128'(exp_idle));
  endtask
  initial begin
    int stray;
    int p1, p2;
    logic [127:0] v1;
    tbl[0] = '{16, 8'h01, 8'h01, 1'b0, 16, 128'h100F0E0D0C0B0A090807060504030201, 136};
    tbl[1] = '{5, 8'h10, 8'h00, 1'b1, 5, 128'h00000000000000000000001010101010, 80};
    tbl[2] = '{1, 8'hAB, 8'h00, 1'b1, 1, 128'h000000000000000000000000000000AB, 171};
    tbl[3] = '{16, 8'hF0, 8'h01, 1'b1, 16, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 3960};
    repeat (3) @(negedge clk);
    chk("reset_vec", o_dat_vector, '0);
    chk("reset_valid", 128'(o_dat_valid), 0);
    chk("reset_cnt", 128'(o_lane_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[r]) begin
      stray = 0;
      for (int i = 0; i < tbl[r].n; i++) begin
        if (o_dat_valid && i > 0) stray++;
        cyc(1'b1, 8'(tbl[r].base + tbl[r].step * i), tbl[r].last && i == tbl[r].n - 1);
      end
      chk($sformatf("t%0d_pulse", r), 128'(o_dat_valid), 1);
      chk($sformatf("t%0d_vec", r), o_dat_vector, tbl[r].exp_vec);
      chk($sformatf("t%0d_cnt", r), 128'(o_lane_count), 128'(tbl[r].exp_cnt));
      chk($sformatf("t%0d_sum", r), 128'(sum_lanes(o_dat_vector)), 128'(tbl[r].exp_sum));
      chk($sformatf("t%0d_stray", r), 128'(stray), 0);
      cyc(1'b0, 8'h00, 1'b0);
      chk($sformatf("t%0d_drop", r), 128'(o_dat_valid), 0);
      chk($sformatf("t%0d_hold", r), o_dat_vector, tbl[r].exp_vec);
    end
    p1 = 0;
    p2 = 0;
    v1 = '0;
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (o_dat_valid && p1 == 0) begin
        p1 = i;
        v1 = o_dat_vector;
      end else if (o_dat_valid) p2 = i;
    end
    chk("b2b_first_at", 128'(p1), 16);
    chk("b2b_second_at", 128'(p2), 32);
    chk("b2b_first_vec", v1, 128'h100F0E0D0C0B0A090807060504030201);
    chk("b2b_second_vec", o_dat_vector, 128'h201F1E1D1C1B1A191817161514131211);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 1'b0);
    wait_pulse("to_idle_cycles", 64);
    chk("to_cnt", 128'(o_lane_count), 3);
    chk("to_vec", o_dat_vector, 128'h030201);
    stray = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (o_dat_valid) stray++;
    end
    chk("to_no_repeat", 128'(stray), 0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    stray = 0;
    for (int i = 0; i < 63; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (o_dat_valid) stray++;
    end
    cyc(1'b1, 8'h03, 1'b0);
    if (o_dat_valid) stray++;
    chk("to_rescue_none", 128'(stray), 0);
    wait_pulse("to_restart_cycles", 64);
    chk("to_restart_cnt", 128'(o_lane_count), 3);
    chk("to_restart_vec", o_dat_vector, 128'h030201);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'hE0 + 8'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vec", o_dat_vector, '0);
    chk("rst_cnt", 128'(o_lane_count), 0);
    chk("rst_valid", 128'(o_dat_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_dat_valid) stray++;
      cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    end
    chk("rst_stray", 128'(stray), 0);
    chk("rst_pulse", 128'(o_dat_valid), 1);
    chk("rst_vec_after", o_dat_vector, 128'h4F4E4D4C4B4A49484746454443424140);
    chk("rst_cnt_after", 128'(o_lane_count), 16);
    cyc(1'b0, 8'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
